// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle barrel-less shifter.
// Each cycle it shifts the working register by at most 3 bit positions
// (LSL, LSR, ASR or ROR) until the latched shift amount is used up.
module seq_shifter #(
  parameter int WIDTH = 33,
  parameter int SHW   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_start,
  input  logic             op_clear,
  input  logic [1:0]       mode,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             busy,
  output logic             op_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_rem;
  logic [1:0]       r_mode;

  logic [1:0]       w_step;
  logic [SHW-1:0]   w_rem_next;
  logic [WIDTH-1:0] w_shifted;

  // Per-cycle step: min(rem, 3), and the remaining count after it
  always_comb begin
    w_step     = (r_rem > SHW'(2)) ? 2'd3 : r_rem[1:0];
    w_rem_next = r_rem - {{(SHW-2){1'b0}}, w_step};
  end

  // Apply w_step single-bit shifts in the latched mode
  always_comb begin
    w_shifted = r_work;
    for (int unsigned i = 0; i < 3; i++) begin
      if (i < {30'd0, w_step}) begin
        case (r_mode)
          M_LSL:   w_shifted = {w_shifted[WIDTH-2:0], 1'b0};
          M_LSR:   w_shifted = {1'b0, w_shifted[WIDTH-1:1]};
          M_ASR:   w_shifted = {w_shifted[WIDTH-1], w_shifted[WIDTH-1:1]};
          M_ROR:   w_shifted = {w_shifted[0], w_shifted[WIDTH-1:1]};
          default: w_shifted = w_shifted;
        endcase
      end
    end
  end

  // Control FSM and datapath registers; clear overrides any start request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_rem   <= '0;
      r_mode  <= '0;
    end else if (op_clear) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_start) begin
            r_work  <= d_in;
            r_mode  <= mode;
            r_rem   <= shamt;
            r_state <= (shamt != '0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          r_work <= w_shifted;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign d_out   = r_work;
  assign busy    = (r_state != S_IDLE);
  assign op_done = (r_state == S_DONE);

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 33, giving the data word width in bits (minimum 4).
REQ-002 The block SHALL have parameter SHW, default 6, giving the shift-amount width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port op_start, input, 1 bit: request a new shift, sampled only in IDLE.
REQ-006 The block SHALL have port op_clear, input, 1 bit: synchronous abort and clear.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 = LSL, 01 = LSR, 10 = ASR, 11 = ROR.
REQ-008 The block SHALL have port shamt, input, SHW bits: unsigned total shift amount.
REQ-009 The block SHALL have port d_in, input, WIDTH bits: operand.
REQ-010 The block SHALL have port d_out, output, WIDTH bits: current contents of the working register.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port op_done, output, 1 bit: one-cycle pulse marking that d_out holds the final result.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 IDLE with op_start=1 SHALL, at the next edge, load d_in into the working register and latch mode and shamt into remaining count rem. The next state is SHIFT if shamt≠0, else DONE.
REQ-015 In SHIFT, each edge SHALL shift the working register by step = min(rem,3) in the latched mode and set rem = rem − step. The next state is DONE when the new rem is 0.
REQ-016 LSL SHALL fill vacated bits with 0.
REQ-017 LSR SHALL fill vacated bits with 0.
REQ-018 ASR SHALL fill vacated bits with the current MSB.
REQ-019 ROR SHALL feed the bits shifted out of bit 0 back into the MSB.
REQ-020 The shift amount is not range-limited. shamt ≥ WIDTH SHALL iterate normally:
- LSL/LSR results become 0;
- ASR results become all copies of the sign bit;
- ROR results equal rotation by shamt mod WIDTH.
REQ-021 DONE SHALL assert op_done for exactly one cycle, hold d_out, and return to IDLE at the next edge.
REQ-022 Latency SHALL be 1 + ceil(shamt/3) edges from the op_start sampling edge to entry into DONE; shamt=0 gives 1 edge.
REQ-023 op_start while busy=1 (including in DONE) SHALL be ignored, with no effect on the operation in progress.
REQ-024 d_out SHALL hold its last value in IDLE until the next load or clear.
REQ-025 op_clear=1 SHALL, at the next edge and in any state, force IDLE, rem=0 and working register=0. op_clear SHALL take priority over op_start. No op_done is generated for the aborted operation.
REQ-026 Changes to d_in, mode or shamt after the load edge SHALL have no effect on the operation in progress.

Reset
REQ-027 Asserting reset SHALL immediately, without waiting for a clock edge, force: state=IDLE, working register=0, rem=0, latched mode=00, d_out=0, busy=0, op_done=0.
REQ-028 reset asserted mid-operation SHALL abort the operation, and no op_done SHALL follow.
REQ-029 Normal operation SHALL resume on the first rising edge after reset deasserts.

Verification
REQ-030 LSL latency (WIDTH=33): d_in=33'h0_0000_0001, shamt=5, op_start pulse -> d_out=33'h0_0000_0020; op_done high exactly in the third cycle after the sampling edge; busy high for 3 cycles.
REQ-031 ASR: d_in=33'h1_0000_0000, shamt=4 -> d_out=33'h1_F000_0000.
REQ-032 ROR wrap: d_in=33'h0_0000_0003, shamt=1 -> d_out=33'h1_0000_0001.
REQ-033 Overshift: d_in all ones, LSR, shamt=40 -> d_out=0 after 14 SHIFT cycles, then op_done.
REQ-034 Zero shift and ignored start: shamt=0 -> op_done on the cycle after load with d_out=d_in. A second op_start during busy is ignored.
REQ-035 Abort:
- op_clear in the second SHIFT cycle -> next cycle d_out=0, busy=0, no op_done;
- reset pulsed between edges -> outputs 0 immediately.
